// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared definitions for the key debouncer slice: the per-channel state
//   encoding and the default parameter values used by the interface and top.
package key_debouncer_pkg;

  // Per-channel debounce state. The two CHECK states are where a candidate
  // level change is being qualified by the counter.
  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } chan_state_e;

  localparam int DEFAULT_N               = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if
//   Groups the key-side bus of the debouncer.
//   key_n : raw active-low push-buttons (driven by the master / board side)
//   level : debounced key state, 1 = pressed (driven by the debouncer)
//   busy  : 1 while a channel is qualifying a candidate change
interface key_debouncer_if
  import key_debouncer_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic [N-1:0] key_n;
  logic [N-1:0] level;
  logic [N-1:0] busy;

  modport master (output key_n, input level, input busy);
  modport slave  (input key_n, output level, output busy);

endinterface

// File: rtl/debounce_channel.sv
// debounce_channel
//   One debounced key: two-flop synchronizer (inverting at the first flop so
//   the synchronized sample is active-high), a four-state FSM and a
//   saturating qualification counter.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low
//   key_n_i  : raw bouncing key, active-low
//   level_o  : debounced state, 1 = pressed
//   busy_o   : 1 while in a CHECK state
module debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer; reset value 0 means "released" after the inversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Qualification FSM: any sample agreeing with the stable state drops back
  // to it, so a single opposite sample restarts qualification. The counter
  // stops at CNT_MAX because the state leaves CHECK on that compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = CHECK_PRESS;
          cnt_d   = '0;
        end
      end
      CHECK_PRESS: begin
        if (!sync2_q)              state_d = RELEASED;
        else if (cnt_q == CNT_MAX) state_d = PRESSED;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = CHECK_RELEASE;
          cnt_d   = '0;
        end
      end
      CHECK_RELEASE: begin
        if (sync2_q)               state_d = PRESSED;
        else if (cnt_q == CNT_MAX) state_d = RELEASED;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only.
  assign level_o = (state_q == PRESSED)     || (state_q == CHECK_RELEASE);
  assign busy_o  = (state_q == CHECK_PRESS) || (state_q == CHECK_RELEASE);

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   N independent debounced push-button channels.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of key_debouncer_if (key_n in, level/busy out)
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N               = DEFAULT_N,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  key_debouncer_if.slave  bus
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .key_n_i (bus.key_n[i]),
      .level_o (bus.level[i]),
      .busy_o  (bus.busy[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Bench for key_debouncer with N = 2, DEBOUNCE_CYCLES = 4. The reference
//   model tracks, per channel, how many consecutive synchronized samples
//   disagree with the debounced level and flips the level when that run
//   reaches DEBOUNCE_CYCLES+1.
module tb_key_debouncer;

  localparam int N  = 2;
  localparam int DC = 4;

  logic clk;
  logic reset;

  key_debouncer_if #(.N(N)) bus ();

  key_debouncer #(
    .N               (N),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream single-pulse stage fed by level[0].
  logic prevLevel;
  logic pulse;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevLevel <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      prevLevel <= bus.level[0];
      pulse     <= bus.level[0] & ~prevLevel;
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [N-1:0] mSyncA, mSyncB, mLevel, mBusy;
  int           mRun [N];

  function automatic void model_reset();
    mSyncA = '0;
    mSyncB = '0;
    mLevel = '0;
    mBusy  = '0;
    for (int i = 0; i < N; i++) mRun[i] = 0;
  endfunction

  // One rising edge of the model: key_n reaches the debounce logic two edges late.
  function automatic void model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (mSyncB[i] != mLevel[i]) begin
        mRun[i]++;
        if (mRun[i] == DC + 1) begin
          mLevel[i] = ~mLevel[i];
          mRun[i]   = 0;
        end
      end else begin
        mRun[i] = 0;
      end
      mBusy[i] = (mRun[i] != 0);
    end
    mSyncB = mSyncA;
    mSyncA = ~bus.key_n;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    bus.key_n = '1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.key_n = '1;
    model_reset();
    repeat (3) tick();
    if (bus.level !== 2'b00) begin errors++; $display("[TB] FAIL reset_level: got %b want 00", bus.level); end
    checks++;
    if (bus.busy !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy: got %b want 00", bus.busy); end
    checks++;
    #3 reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_clean_press();
    bus.key_n = 2'b10;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (bus.busy[0] !== ((e >= 3 && e <= 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL press_busy0 edge %0d: got %b want %b", e, bus.busy[0], (e >= 3 && e <= 6));
      end
      checks++;
      if (bus.level[0] !== ((e >= 7) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL press_level0 edge %0d: got %b want %b", e, bus.level[0], (e >= 7));
      end
      checks++;
      if (bus.level[1] !== 1'b0) begin
        errors++; $display("[TB] FAIL press_level1 edge %0d: got %b want 0", e, bus.level[1]);
      end
      checks++;
      if (bus.level !== mLevel || bus.busy !== mBusy) begin
        errors++; $display("[TB] FAIL press_model edge %0d: got %b/%b want %b/%b", e, bus.level, bus.busy, mLevel, mBusy);
      end
      checks++;
    end
  endtask

  task automatic test_clean_release();
    bus.key_n = 2'b11;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (bus.level[0] !== ((e < 7) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL release_level0 edge %0d: got %b want %b", e, bus.level[0], (e < 7));
      end
      checks++;
    end
    // Re-press, then a 2-cycle release glitch must not drop the level.
    bus.key_n = 2'b10;
    repeat (10) tick();
    bus.key_n = 2'b11;
    repeat (2) tick();
    bus.key_n = 2'b10;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.level[0] !== 1'b1) begin
        errors++; $display("[TB] FAIL release_glitch edge %0d: got %b want 1", e, bus.level[0]);
      end
      checks++;
      if (bus.level !== mLevel || bus.busy !== mBusy) begin
        errors++; $display("[TB] FAIL release_model edge %0d: got %b/%b want %b/%b", e, bus.level, bus.busy, mLevel, mBusy);
      end
      checks++;
    end
    settle();
  endtask

  task automatic test_bounce();
    bus.key_n = 2'b10;
    repeat (3) tick();
    bus.key_n = 2'b11;
    tick();
    if (bus.level[0] !== 1'b0) begin errors++; $display("[TB] FAIL bounce_glitch: got %b want 0", bus.level[0]); end
    checks++;
    bus.key_n = 2'b10;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (bus.level[0] !== ((e >= 7) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL bounce_level0 edge %0d: got %b want %b", e, bus.level[0], (e >= 7));
      end
      checks++;
    end
    settle();
  endtask

  task automatic test_simultaneous();
    bus.key_n = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (bus.level !== ((e >= 7) ? 2'b11 : 2'b00)) begin
        errors++; $display("[TB] FAIL simul_press edge %0d: got %b want %b", e, bus.level, (e >= 7) ? 2'b11 : 2'b00);
      end
      checks++;
    end
    bus.key_n = 2'b10;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (bus.level !== ((e >= 7) ? 2'b01 : 2'b11)) begin
        errors++; $display("[TB] FAIL simul_release1 edge %0d: got %b want %b", e, bus.level, (e >= 7) ? 2'b01 : 2'b11);
      end
      checks++;
    end
    settle();
  endtask

  task automatic test_reset_mid_count();
    bus.key_n = 2'b10;
    repeat (5) tick();
    if (bus.busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before: got %b want 1", bus.busy[0]); end
    checks++;
    #2 reset = 1'b0;
    #1;
    if (bus.level !== 2'b00 || bus.busy !== 2'b00) begin
      errors++; $display("[TB] FAIL midreset_async: got %b/%b want 00/00", bus.level, bus.busy);
    end
    checks++;
    repeat (2) tick();
    #3 reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (bus.level[0] !== ((e >= 7) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL midreset_requal edge %0d: got %b want %b", e, bus.level[0], (e >= 7));
      end
      checks++;
    end
    settle();
  endtask

  task automatic test_pulse_chain();
    int highCount;
    int rises;
    logic last;
    highCount = 0;
    rises     = 0;
    last      = pulse;
    bus.key_n = 2'b10;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (pulse) highCount++;
      if (pulse && !last) rises++;
      last = pulse;
    end
    bus.key_n = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (pulse) highCount++;
      if (pulse && !last) rises++;
      last = pulse;
    end
    if (rises !== 1) begin errors++; $display("[TB] FAIL pulse_count: got %0d want 1", rises); end
    checks++;
    if (highCount !== 1) begin errors++; $display("[TB] FAIL pulse_width: got %0d want 1", highCount); end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) bus.key_n[i] = ~bus.key_n[i];
      end
      tick();
      if (bus.level !== mLevel || bus.busy !== mBusy) begin
        errors++; $display("[TB] FAIL random_model cycle %0d: got %b/%b want %b/%b", c, bus.level, bus.busy, mLevel, mBusy);
      end
      checks++;
    end
    settle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_pulse_chain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
